// File: rtl/bt_stream_packetiser.sv
// bt_stream_packetiser
//   Snapshots NUM_CH status words of DATA_W bits and streams them to the HC-05
//   as a framed, checksummed packet over an 8N1 UART line:
//     A5, CNT, { id, data MSB..LSB } per enabled channel, CHK (XOR after A5).
//   Single-shot on `start`, or repeating with a GAP_CYCLES pause while `cont`.
// Ports
//   clock, resetn        : clock and asynchronous active-low reset
//   bt_state             : HC-05 STATE pin, 1 = link up
//   start, cont          : one-packet request / continuous-mode enable
//   ch_mask, ch_data     : per-channel enable and packed channel words
//   fpga_txd             : UART TX to HC-05 RXD, idles high
//   busy, done, abort    : in-flight flag, completion pulse, abandon pulse
//   pkt_count            : completed packet counter, wraps at 16 bits
module bt_stream_packetiser #(
  parameter int NUM_CH       = 10,
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 104,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     bt_state,
  input  logic                     start,
  input  logic                     cont,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     fpga_txd,
  output logic                     busy,
  output logic                     done,
  output logic                     abort,
  output logic [15:0]              pkt_count
);

  localparam int NB    = DATA_W / 8;
  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int SEL_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int BC_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CH_W-1:0] NO_CH = CH_W'(NUM_CH);

  typedef enum logic [2:0] {IDLE, LATCH, HDR, CNT, CHID, DATA, CHK, GAP} pkt_state_t;
  typedef enum logic [1:0] {TIDLE, START, BITS, STOP} tx_state_t;

  pkt_state_t               pstate, nxt_state;
  tx_state_t                tstate;
  logic [NUM_CH-1:0]        snap_mask;
  logic [NUM_CH*DATA_W-1:0] snap_data;
  logic [7:0]               cnt_byte, chk, tx_shift, nxt_byte, mask_pop;
  logic [CH_W-1:0]          ch_idx, nxt_ch, first_ch, next_ch;
  logic [SEL_W-1:0]         sel, nxt_sel;
  logic [BC_W-1:0]          bit_cnt;
  logic [2:0]               bit_idx;
  logic [31:0]              gap_cnt;
  logic                     link_lost;
  logic                     bit_end, byte_end, launch;

  function automatic logic [7:0] pick_byte(input logic [NUM_CH*DATA_W-1:0] d,
                                           input int ch, input int s);
    return d[ch*DATA_W + (NB-1-s)*8 +: 8];
  endfunction

  assign bit_end  = (bit_cnt == BC_W'(CLKS_PER_BIT - 1));
  assign byte_end = (tstate == STOP) && bit_end;
  // The header is the only byte launched from an idle transmitter; every later
  // byte is launched on the stop-bit edge of the previous one, so no line gaps.
  assign launch   = byte_end || ((pstate == HDR) && (tstate == TIDLE));

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < NUM_CH; i++) mask_pop = mask_pop + 8'(ch_mask[i]);
  end

  // Lowest enabled channel overall, and lowest enabled channel above ch_idx.
  always_comb begin
    first_ch = NO_CH;
    next_ch  = NO_CH;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap_mask[i]) begin
        first_ch = CH_W'(i);
        if (i > int'(ch_idx)) next_ch = CH_W'(i);
      end
    end
  end

  // Which byte follows the one currently on the line.
  always_comb begin
    nxt_state = pstate;
    nxt_byte  = 8'hA5;
    nxt_ch    = ch_idx;
    nxt_sel   = sel;
    case (pstate)
      HDR: begin
        if (tstate != TIDLE) begin
          nxt_state = CNT;
          nxt_byte  = cnt_byte;
        end
      end
      CNT: begin
        if (first_ch != NO_CH) begin
          nxt_state = CHID;
          nxt_ch    = first_ch;
          nxt_byte  = 8'(first_ch);
        end else begin
          nxt_state = CHK;
          nxt_byte  = chk;
        end
      end
      CHID: begin
        nxt_state = DATA;
        nxt_sel   = '0;
        nxt_byte  = pick_byte(snap_data, int'(ch_idx), 0);
      end
      DATA: begin
        if (int'(sel) != NB - 1) begin
          nxt_sel  = sel + 1'b1;
          nxt_byte = pick_byte(snap_data, int'(ch_idx), int'(sel) + 1);
        end else if (next_ch != NO_CH) begin
          nxt_state = CHID;
          nxt_ch    = next_ch;
          nxt_byte  = 8'(next_ch);
        end else begin
          nxt_state = CHK;
          nxt_byte  = chk;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order. Within this block a
  // later assignment overrides the byte engine's default step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pstate    <= IDLE;
      tstate    <= TIDLE;
      fpga_txd  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
      pkt_count <= '0;
      // NOTE: the snapshot is a plain register bank, not a RAM, so it is reset
      // with everything else and never feeds X toward the line.
      snap_mask <= '0;
      snap_data <= '0;
      cnt_byte  <= '0;
      chk       <= '0;
      tx_shift  <= '0;
      ch_idx    <= '0;
      sel       <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
      link_lost <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;

      // Byte engine: start bit, 8 data bits LSB first, stop bit.
      case (tstate)
        START: begin
          if (bit_end) begin
            tstate   <= BITS;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            fpga_txd <= tx_shift[0];
          end else bit_cnt <= bit_cnt + 1'b1;
        end
        BITS: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tstate   <= STOP;
              fpga_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              tx_shift <= tx_shift >> 1;
              fpga_txd <= tx_shift[1];
            end
          end else bit_cnt <= bit_cnt + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            tstate  <= TIDLE;
            bit_cnt <= '0;
          end else bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase

      // Packet sequencer.
      case (pstate)
        IDLE: begin
          if ((start || cont) && bt_state) begin
            pstate <= LATCH;
            busy   <= 1'b1;
          end
        end
        LATCH: begin
          snap_mask <= ch_mask;
          snap_data <= ch_data;
          cnt_byte  <= mask_pop;
          chk       <= '0;
          ch_idx    <= '0;
          sel       <= '0;
          link_lost <= 1'b0;
          pstate    <= HDR;
        end
        HDR, CNT, CHID, DATA, CHK: begin
          // A link drop is remembered so the abort happens even if the pin
          // bounces back before the current byte ends.
          if (!bt_state) link_lost <= 1'b1;
          if (byte_end && (link_lost || !bt_state)) begin
            pstate <= IDLE;
            busy   <= 1'b0;
            abort  <= 1'b1;
          end else if (byte_end && (pstate == CHK)) begin
            done      <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
            if (cont) begin
              pstate  <= GAP;
              gap_cnt <= '0;
            end else begin
              pstate <= IDLE;
              busy   <= 1'b0;
            end
          end else if (launch) begin
            pstate   <= nxt_state;
            ch_idx   <= nxt_ch;
            sel      <= nxt_sel;
            tx_shift <= nxt_byte;
            tstate   <= START;
            bit_cnt  <= '0;
            fpga_txd <= 1'b0;
            if (nxt_state inside {CNT, CHID, DATA}) chk <= chk ^ nxt_byte;
          end
        end
        GAP: begin
          // GAP_CYCLES cycles here plus LATCH and the header launch put the
          // next start bit GAP_CYCLES+2 cycles after done.
          if (gap_cnt + 32'd1 >= 32'(GAP_CYCLES)) begin
            if (cont && bt_state) pstate <= LATCH;
            else begin
              pstate <= IDLE;
              busy   <= 1'b0;
            end
          end else gap_cnt <= gap_cnt + 32'd1;
        end
        default: pstate <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bt_stream_packetiser.sv
// Self-checking bench for bt_stream_packetiser: a UART receiver decodes the
// line, and a queue-based packet model built from the framing rules supplies
// the expected bytes and timing.
module tb_bt_stream_packetiser;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int CPB    = 4;
  localparam int GAP    = 10;
  localparam int NB     = DATA_W / 8;
  localparam logic [7:0] LIT [9] = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34,
                                     8'h02, 8'hAB, 8'hCD, 8'h40};

  logic clock = 1'b0, resetn = 1'b0, bt_state = 1'b1, start = 1'b0, cont = 1'b0;
  logic [NUM_CH-1:0]        ch_mask = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic fpga_txd, busy, done, abort;
  logic [15:0] pkt_count;

  int total = 0, bad = 0, cyc = 0, exp_count = 0, frame_err = 0;
  logic [7:0] exp_q[$], rx_q[$];
  int rx_start[$];

  bt_stream_packetiser #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock), .resetn(resetn), .bt_state(bt_state), .start(start),
    .cont(cont), .ch_mask(ch_mask), .ch_data(ch_data), .fpga_txd(fpga_txd),
    .busy(busy), .done(done), .abort(abort), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // UART receiver: mid-bit sampling on falling clock edges.
  int mon_cnt = 0, mon_t = 0;
  bit mon_busy = 0;
  logic [7:0] mon_byte;
  initial begin : uart_mon
    forever begin
      @(negedge clock);
      if (!resetn) mon_busy = 0;
      else if (!mon_busy) begin
        if (fpga_txd === 1'b0) begin
          mon_busy = 1; mon_cnt = 0; mon_t = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          if (mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8) mon_byte[mon_cnt/CPB - 1] = fpga_txd;
          else if (mon_cnt / CPB == 9) begin
            if (fpga_txd !== 1'b1) frame_err++;
            rx_q.push_back(mon_byte);
            rx_start.push_back(mon_t);
            mon_busy = 0;
          end
        end
      end
    end
  end

  // Packet model straight from the framing rules.
  function automatic void build_expected(input logic [NUM_CH-1:0] m,
                                         input logic [NUM_CH*DATA_W-1:0] d);
    logic [7:0] c;
    logic [DATA_W-1:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    c = 8'($countones(m));
    exp_q.push_back(c);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m[ch]) begin
        w = d[ch*DATA_W +: DATA_W];
        exp_q.push_back(8'(ch));
        c ^= 8'(ch);
        for (int b = NB - 1; b >= 0; b--) begin
          exp_q.push_back(w[b*8 +: 8]);
          c ^= w[b*8 +: 8];
        end
      end
    end
    exp_q.push_back(c);
  endfunction

  task automatic pulse_start(output int k);
    @(negedge clock);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int done_at, output int abort_at);
    done_at = -1;
    abort_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin done_at = cyc; break; end
      if (abort === 1'b1) begin abort_at = cyc; break; end
    end
  endtask

  task automatic send_packet(input logic [NUM_CH-1:0] m, input logic [NUM_CH*DATA_W-1:0] d,
                             output int k, output int done_at, output int abort_at);
    build_expected(m, d);
    ch_mask = m;
    ch_data = d;
    rx_q.delete();
    rx_start.delete();
    pulse_start(k);
    wait_end(1000, done_at, abort_at);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++; if (fpga_txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", fpga_txd); end
    total++; if ({busy, done, abort} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, abort}); end
    total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pkt_count); end
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    total++; if ({fpga_txd, busy} !== 2'b10) begin bad++; $display("FAIL idle_after_reset got=%b exp=10", {fpga_txd, busy}); end
  endtask

  task automatic test_single();
    int k, dn, ab;
    send_packet(4'b0101, {16'h5A5A, 16'hABCD, 16'h7777, 16'h1234}, k, dn, ab);
    exp_count++;
    total++; if (rx_q.size() != 9) begin bad++; $display("FAIL single_len got=%0d exp=9", rx_q.size()); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== LIT[i]) begin
        bad++; $display("FAIL single_byte%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, LIT[i]);
      end
    end
    total++; if (rx_start.size() == 0 || rx_start[0] != k + 2) begin bad++; $display("FAIL single_first_start got=%0d exp=%0d", (rx_start.size() > 0) ? rx_start[0] : -1, k + 2); end
    total++; if (dn != k + 2 + 360) begin bad++; $display("FAIL single_done_time got=%0d exp=%0d", dn, k + 362); end
    total++; if (pkt_count !== 16'(exp_count)) begin bad++; $display("FAIL single_count got=%0d exp=%0d", pkt_count, exp_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_zero_mask();
    int k, dn, ab;
    send_packet(4'b0000, {$urandom(), $urandom()}, k, dn, ab);
    exp_count++;
    total++; if (rx_q.size() != 3) begin bad++; $display("FAIL zero_len got=%0d exp=3", rx_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL zero_byte%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (dn != k + 2 + 120) begin bad++; $display("FAIL zero_done_time got=%0d exp=%0d", dn, k + 122); end
  endtask

  task automatic test_snapshot();
    int k, dn, ab;
    logic [63:0] d;
    d = {$urandom(), 16'hABCD, $urandom_range(65535, 0), 16'h1234};
    build_expected(4'b0101, d);
    ch_mask = 4'b0101; ch_data = d;
    rx_q.delete(); rx_start.delete();
    pulse_start(k);
    @(negedge clock);  // LATCH has captured; disturb the inputs now
    ch_data[15:0] = 16'hFFFF;
    ch_mask = 4'b1111;
    wait_end(1000, dn, ab);
    exp_count++;
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL snap_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL snap_byte%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (dn != k + 2 + 40 * exp_q.size()) begin bad++; $display("FAIL snap_done_time got=%0d exp=%0d", dn, k + 2 + 40 * exp_q.size()); end
  endtask

  task automatic test_random();
    int k, dn, ab;
    for (int n = 0; n < 5; n++) begin
      send_packet(4'($urandom()), {$urandom(), $urandom()}, k, dn, ab);
      exp_count++;
      total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", n, rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        total++;
        if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", n, i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
        end
      end
      total++; if (dn != k + 2 + 40 * exp_q.size()) begin bad++; $display("FAIL rand%0d_done_time got=%0d exp=%0d", n, dn, k + 2 + 40 * exp_q.size()); end
      total++; if (pkt_count !== 16'(exp_count)) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, pkt_count, exp_count); end
    end
    total++; if (frame_err != 0) begin bad++; $display("FAIL framing got=%0d exp=0", frame_err); end
  endtask

  task automatic test_start_while_busy();
    int k, k2, dn, ab;
    build_expected(4'b1001, {$urandom(), $urandom()});
    ch_mask = 4'b1001; ch_data = {$urandom(), $urandom()};
    build_expected(ch_mask, ch_data);
    rx_q.delete(); rx_start.delete();
    pulse_start(k);
    repeat (50) @(negedge clock);
    pulse_start(k2);
    wait_end(1000, dn, ab);
    exp_count++;
    repeat (60) @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_ignored got=%b exp=0", busy); end
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL busy_start_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    total++; if (pkt_count !== 16'(exp_count)) begin bad++; $display("FAIL busy_start_count got=%0d exp=%0d", pkt_count, exp_count); end
  endtask

  task automatic test_link_loss();
    int k, dn, ab;
    ch_mask = 4'b0101; ch_data = {$urandom(), $urandom()};
    build_expected(ch_mask, ch_data);
    rx_q.delete(); rx_start.delete();
    pulse_start(k);
    while (cyc < k + 2 + 120 + 10) @(negedge clock);
    bt_state = 1'b0;
    wait_end(1000, dn, ab);
    total++; if (ab != k + 2 + 160) begin bad++; $display("FAIL loss_abort_time got=%0d exp=%0d", ab, k + 162); end
    total++; if (dn != -1) begin bad++; $display("FAIL loss_no_done got=%0d exp=-1", dn); end
    total++; if ({busy, fpga_txd} !== 2'b01) begin bad++; $display("FAIL loss_line got=%b exp=01", {busy, fpga_txd}); end
    total++; if (rx_q.size() != 4) begin bad++; $display("FAIL loss_len got=%0d exp=4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL loss_byte%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    pulse_start(k);
    repeat (40) @(negedge clock);
    total++; if (busy !== 1'b0 || rx_q.size() != 4) begin bad++; $display("FAIL nolink_start busy=%b bytes=%0d exp busy=0 bytes=4", busy, rx_q.size()); end
    total++; if (pkt_count !== 16'(exp_count)) begin bad++; $display("FAIL loss_count got=%0d exp=%0d", pkt_count, exp_count); end
    bt_state = 1'b1;
  endtask

  task automatic test_reset_mid();
    int k, dn, ab;
    ch_mask = 4'($urandom()); ch_data = {$urandom(), $urandom()};
    rx_q.delete(); rx_start.delete();
    pulse_start(k);
    while (cyc < k + 2 + 10) @(negedge clock);  // header data bit 1, a 0 for A5
    total++; if (fpga_txd !== 1'b0) begin bad++; $display("FAIL midbit_level got=%b exp=0", fpga_txd); end
    resetn = 1'b0;
    #1;
    total++; if ({fpga_txd, busy} !== 2'b10) begin bad++; $display("FAIL midreset_line got=%b exp=10", {fpga_txd, busy}); end
    total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", pkt_count); end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    exp_count = 0;
    send_packet(4'($urandom()), {$urandom(), $urandom()}, k, dn, ab);
    exp_count++;
    total++; if (rx_q.size() != exp_q.size()) begin bad++; $display("FAIL postreset_len got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL postreset_byte%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL postreset_count got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_continuous();
    int k, d1, d2, d3, ab, b, s2;
    ch_mask = 4'($urandom()); ch_data = {$urandom(), $urandom()};
    build_expected(ch_mask, ch_data);
    b = exp_q.size();
    rx_q.delete(); rx_start.delete();
    @(negedge clock);
    cont = 1'b1;
    k = cyc + 1;
    wait_end(1000, d1, ab);
    total++; if (d1 != k + 2 + 40 * b) begin bad++; $display("FAIL cont_done1 got=%0d exp=%0d", d1, k + 2 + 40 * b); end
    wait_end(1000, d2, ab);
    s2 = (rx_start.size() > b) ? rx_start[b] : -1;
    total++; if (s2 != d1 + GAP + 2) begin bad++; $display("FAIL cont_gap got=%0d exp=%0d", s2, d1 + GAP + 2); end
    total++; if (d2 != d1 + GAP + 2 + 40 * b) begin bad++; $display("FAIL cont_done2 got=%0d exp=%0d", d2, d1 + GAP + 2 + 40 * b); end
    while (cyc < d2 + GAP + 2 + 5) @(negedge clock);
    cont = 1'b0;
    wait_end(1000, d3, ab);
    exp_count += 3;
    total++; if (d3 != d2 + GAP + 2 + 40 * b) begin bad++; $display("FAIL cont_done3 got=%0d exp=%0d", d3, d2 + GAP + 2 + 40 * b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_busy_end got=%b exp=0", busy); end
    repeat (GAP + 40) @(negedge clock);
    total++; if (rx_q.size() != 3 * b) begin bad++; $display("FAIL cont_len got=%0d exp=%0d", rx_q.size(), 3 * b); end
    for (int i = 0; i < 3 * b; i++) begin
      total++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i % b]) begin
        bad++; $display("FAIL cont_byte%0d got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i % b]);
      end
    end
    total++; if (pkt_count !== 16'(exp_count)) begin bad++; $display("FAIL cont_count got=%0d exp=%0d", pkt_count, exp_count); end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_zero_mask();
    test_snapshot();
    test_random();
    test_start_while_busy();
    test_link_loss();
    test_reset_mid();
    test_continuous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_stream_packetiser.md
# bt_stream_packetiser

Parametrised N-channel packetiser and UART transmitter that streams snapshots of FPGA status words to the HC-05 module. It sits between the wireOut-style status buses inside the Bluetooth connection logic and the HC-05 RXD pin. It generalises the fixed ten-word status set to `NUM_CH` channels of `DATA_W` bits, sent as framed, checksummed packets in single-shot or continuous mode.

## Interface
- `NUM_CH`, default 10: channel count, range 1..255.
- `DATA_W`, default 16: bits per channel; must be a multiple of 8. `NB = DATA_W/8`.
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (1 MHz clock, ~9600 baud); must be ≥ 2.
- `GAP_CYCLES`, default 1000: idle cycles between packets in continuous mode.
- `clock` input 1: the block's single clock.
- `resetn` input 1: asynchronous, active-low reset.
- `bt_state` input 1: HC-05 STATE pin; 1 means a link is connected.
- `start` input 1: single-cycle request for one packet.
- `cont` input 1: continuous mode enable.
- `ch_mask` input NUM_CH: per-channel enable; bit i selects channel i.
- `ch_data` input NUM_CH*DATA_W: channel i occupies `[i*DATA_W +: DATA_W]`.
- `fpga_txd` output 1: UART TX line to HC-05 RXD; idles high.
- `busy` output 1: high while a packet is in flight or during the continuous-mode gap.
- `done` output 1: one-cycle pulse when a packet completes.
- `abort` output 1: one-cycle pulse when a packet is abandoned.
- `pkt_count` output 16: number of completed packets; wraps 0xFFFF→0.

## Operation
- Packet byte order:
  - `0xA5` header.
  - `CNT`, the popcount of the latched mask.
  - For each enabled channel, in ascending index order: channel id byte, then `NB` data bytes, MSB first.
  - `CHK`, the XOR of every byte after the header.
- Each byte is sent as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Packet FSM states are IDLE, LATCH, HDR, CNT, CHID, DATA, CHK and GAP.
  - IDLE→LATCH when `(start | cont) & bt_state`.
  - LATCH captures `ch_mask` and `ch_data` into a snapshot register, computes CNT and clears the checksum, all in one cycle.
  - HDR→CNT→(CHID→DATA×NB per enabled channel)→CHK.
  - After CHK, go to GAP if `cont` is 1, otherwise to IDLE.
  - GAP counts `GAP_CYCLES`, then goes to LATCH if `cont & bt_state`, otherwise to IDLE.
- Disabled channels are skipped with zero bit-time cost. The channel scan may take at most one cycle per channel. Scan cycles are inserted only between bytes, and the stop bit already covers them, so no extra gap cycles appear on the line when `CLKS_PER_BIT ≥ NUM_CH`. The bench uses parameters that satisfy this.
- If the latched mask is 0, the packet is `A5 00 00`.
- Byte sub-FSM states are TIDLE, START, BITS and STOP. A bit counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..7.
- `ch_data` and `ch_mask` changes after LATCH do not affect the packet in flight.
- `start` while busy is ignored; it is not queued. `start` while `bt_state` is 0 is ignored.
- If `bt_state` falls mid-packet:
  - The current byte finishes, including its stop bit.
  - The FSM then returns to IDLE and pulses `abort`.
  - `done` does not pulse and `pkt_count` does not increment.
  - `cont` does not restart the packet until `bt_state` returns to 1.
- Clearing `cont` mid-packet finishes the current packet normally, then the FSM goes to IDLE.
- `resetn` low at any time, including mid-byte, applies the reset values immediately.

## Timing
- Reset values: `fpga_txd`=1, `busy`=0, `done`=0, `abort`=0, `pkt_count`=0. All FSMs are in their idle states.
- Outputs are registered.
- `start` sampled high at edge k → `busy`=1 and LATCH at k+1 → `fpga_txd` falls (header start bit) at k+2.
- Each byte lasts exactly 10·CLKS_PER_BIT cycles, with no gaps between bytes.
- For a packet of B bytes, the line returns high after the final stop bit at edge k+2+10·CLKS_PER_BIT·B.
  - `done` pulses at that same edge.
  - `pkt_count` increments at that same edge.
  - `busy` falls at that same edge unless the FSM enters GAP.
- B = 3 + E·(1+NB), where E is the number of enabled channels.
- In continuous mode, the next header start bit occurs GAP_CYCLES+2 cycles after `done`.
- `abort` pulses at the end of the stop bit of the byte in flight. `busy` falls in the same cycle.

## Test plan
- Single packet (NUM_CH=4, DATA_W=16, CLKS_PER_BIT=4):
  - Stimulus: `ch_mask`=4'b0101, ch0=0x1234, ch2=0xABCD, pulse `start`.
  - Required: UART decodes `A5 02 00 12 34 02 AB CD 40`; `done` pulses 2+360 cycles after `start`; `pkt_count`=1.
- Zero mask: pulse `start` → bytes `A5 00 00`; `done` after 2+120 cycles.
- Snapshot: change ch0 to 0xFFFF one cycle after LATCH → the packet still carries `12 34`.
- Link loss: drop `bt_state` during the 4th byte → that byte completes; `abort` pulses; no `done`; `pkt_count` unchanged; `fpga_txd`=1 afterwards.
- Continuous mode: with `cont`=1 and GAP_CYCLES=10, three packets are sent back-to-back with 12-cycle spacing between `done` and the next start bit; clearing `cont` lets the current packet finish, then the block goes idle; `pkt_count`=3.
- Reset: assert `resetn`=0 mid data bit → `fpga_txd`=1 and `busy`=0 immediately; `pkt_count`=0; a `start` after release sends a clean packet.
